icache_fetch_ctrl: RTL and testbench
====================================

// Module: icache_fetch_ctrl
// PURPOSE
//  Fetch-side controller for the direct-mapped, one-word-per-line instruction cache.
//  Sits between the IF stage, the cache array (combinational lookup) and the byte-wide RAM arbiter.
//  A hit is returned the next cycle. A miss is refilled with four byte reads, written into the cache, then returned.
// PARAMETERS
//  ADDR_WIDTH  32  byte-address width of fetch/cache/memory addresses
//  CNT_WIDTH   32  width of perf counters (only with ICACHE_PERF_CNT_EN)
// PORTS
//  clkIn        in   1   clock, all state on posedge
//  rstIn        in   1   reset, asynchronous, active-low
//  rdyIn        in   1   global ready; 0 = freeze every register (memory side frozen identically)
//  fetchReq     in   1   IF requests instruction at fetchAddr
//  fetchAddr    in   AW  word-aligned PC (bits [1:0] ignored)
//  fetchFlush   in   1   discard any pending/returning instruction
//  fetchBusy    out  1   state != IDLE; fetchReq is ignored while high
//  fetchRdy     out  1   1-cycle pulse: fetchData valid
//  fetchData    out  32  returned instruction
//  cacheAddr    out  AW  lookup/write address to cache
//  cacheHit     in   1   cache hit for cacheAddr
//  cacheData    in   32  cache word for cacheAddr
//  cacheWrEn    out  1   write assembled word into cache
//  cacheWrData  out  32  word to write
//  memReq       out  1   request a byte read from the arbiter
//  memAddr      out  AW  byte address = {lineAddr[AW-1:2], issueCnt[1:0]}
//  memGnt       in   1   read issued this cycle; byte returns the next cycle
//  memData      in   8   returned byte
// BEHAVIOUR
//  Reset (rstIn=0, async): state=IDLE; fetchRdy, fetchBusy, cacheWrEn, memReq=0; fetchData, cacheWrData, memAddr=0; counters=0.
//  Reset mid-refill aborts it: no cache write, no fetchRdy.
//  States: IDLE, REFILL, DRAIN, WRITE. All transitions are gated by rdyIn=1.
//  IDLE: cacheAddr = fetchAddr (combinational).
//   fetchReq & !fetchFlush & cacheHit -> next cycle fetchRdy=1, fetchData=cacheData (registered); stay IDLE.
//   fetchReq & !fetchFlush & !cacheHit -> latch lineAddr=fetchAddr&~3; issueCnt=0, rcvCnt=0, drop=0; -> REFILL.
//   fetchFlush=1 -> request ignored. A fetchRdy already scheduled for the next cycle is cancelled.
//  REFILL: memReq=1, memAddr=lineAddr+issueCnt. Each memGnt: issueCnt++.
//   Grant of byte 3 -> DRAIN. memReq drops to 0 the cycle after the 4th grant.
//  Byte capture (REFILL/DRAIN): the cycle after each grant, memData -> word[8*rcvCnt+:8], rcvCnt++ (little-endian).
//  DRAIN: wait for 4th byte; then -> WRITE.
//  WRITE (1 cycle): cacheAddr=lineAddr, cacheWrEn=1, cacheWrData=word; fetchRdy=!drop, fetchData=word; -> IDLE.
//  Outside WRITE, cacheAddr=lineAddr whenever state != IDLE.
//  fetchFlush in REFILL/DRAIN/WRITE sets drop=1 (WRITE: fetchRdy forced 0 that cycle).
//   The refill still completes and the cache is still written.
//  Latency, memGnt held 1, rdyIn=1, request in cycle 0: hit -> fetchRdy cycle 1; miss -> REFILL cycles 1-4, DRAIN cycle 5, WRITE+fetchRdy cycle 6.
//   Each grant-stall cycle adds 1.
//  memGnt while memReq=0 is illegal and is ignored.
//  fetchReq during fetchBusy is ignored; IF must hold it.
//  Back-to-back: a new fetchReq is accepted in the cycle after WRITE (IDLE).
//  lineAddr increment never carries past bit 1; no wrap into the next word.
// CONFIGURATION
//  ICACHE_PERF_CNT_EN defined: extra outputs hitCnt, missCnt [CNT_WIDTH-1:0].
//   Increment on each accepted hit / miss (flushed requests are not counted). Wrap modulo 2^CNT_WIDTH; reset to 0.
//  Undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  Cold miss: fetchAddr=0x1000, memGnt=1, memData bytes 13,00,A0,00 -> cacheWrEn & fetchRdy cycle 6, data 0x00A00013.
//  Hit after fill: re-request 0x1000 with cacheHit=1 -> fetchRdy cycle 1, data=cacheData, memReq stays 0.
//  Grant stalls: memGnt low on alternating cycles -> 4 reads at 0x1000..0x1003, correct byte order, WRITE cycle 10.
//  Flush mid-refill: fetchFlush at cycle 3 -> cacheWrEn still pulses with full word; fetchRdy never asserted.
//  rdyIn low 5 cycles in REFILL -> no state/counter change; result equals the no-stall case shifted by 5.
//  Async reset at cycle 3 of refill -> all outputs 0 immediately, IDLE; no cacheWrEn.
//   With ICACHE_PERF_CNT_EN: missCnt=0.

Source files
------------

// File: rtl/icache_fetch_ctrl.sv
// Fetch controller for a direct-mapped, one-word-per-line icache with byte-wide refill.
// Optional hit/miss performance counters are enabled by ICACHE_PERF_CNT_EN.
module icache_fetch_ctrl #(
    parameter int ADDR_WIDTH = 32
`ifdef ICACHE_PERF_CNT_EN
    ,
    parameter int CNT_WIDTH  = 32
`endif
) (
    input  logic                  clkIn,
    input  logic                  rstIn,
    input  logic                  rdyIn,
    input  logic                  fetchReq,
    input  logic [ADDR_WIDTH-1:0] fetchAddr,
    input  logic                  fetchFlush,
    output logic                  fetchBusy,
    output logic                  fetchRdy,
    output logic [31:0]           fetchData,
    output logic [ADDR_WIDTH-1:0] cacheAddr,
    input  logic                  cacheHit,
    input  logic [31:0]           cacheData,
    output logic                  cacheWrEn,
    output logic [31:0]           cacheWrData,
    output logic                  memReq,
    output logic [ADDR_WIDTH-1:0] memAddr,
    input  logic                  memGnt,
    input  logic [7:0]            memData
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]  hitCnt,
    output logic [CNT_WIDTH-1:0]  missCnt
`endif
);

    typedef enum logic [1:0] {IDLE, REFILL, DRAIN, WRITE} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-3:0] lineAddr_q, lineAddr_d;
    logic [1:0]            issueCnt_q, issueCnt_d;
    logic [1:0]            rcvCnt_q, rcvCnt_d;
    logic                  capPend_q, capPend_d;
    logic                  drop_q, drop_d;
    logic [31:0]           word_q, word_d;
    logic                  fetchRdy_q, fetchRdy_d;
    logic [31:0]           fetchData_q, fetchData_d;
    logic                  accept;

    assign accept = (state_q == IDLE) && fetchReq && !fetchFlush;

    always_comb begin
        state_d     = state_q;
        lineAddr_d  = lineAddr_q;
        issueCnt_d  = issueCnt_q;
        rcvCnt_d    = rcvCnt_q;
        capPend_d   = 1'b0;
        drop_d      = drop_q;
        word_d      = word_q;
        fetchRdy_d  = 1'b0;
        fetchData_d = fetchData_q;
        // a byte granted last cycle is on memData now
        if (capPend_q) begin
            word_d[8*rcvCnt_q +: 8] = memData;
            rcvCnt_d = rcvCnt_q + 2'd1;
        end
        unique case (state_q)
            IDLE: begin
                if (accept && cacheHit) begin
                    fetchRdy_d  = 1'b1;
                    fetchData_d = cacheData;
                end else if (accept) begin
                    lineAddr_d = fetchAddr[ADDR_WIDTH-1:2];
                    issueCnt_d = 2'd0;
                    rcvCnt_d   = 2'd0;
                    drop_d     = 1'b0;
                    state_d    = REFILL;
                end
            end
            REFILL: begin
                if (fetchFlush) drop_d = 1'b1;
                if (memGnt) begin
                    capPend_d  = 1'b1;
                    issueCnt_d = issueCnt_q + 2'd1;
                    if (issueCnt_q == 2'd3) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (fetchFlush) drop_d = 1'b1;
                if (capPend_q && rcvCnt_q == 2'd3) begin
                    fetchRdy_d  = !drop_d;
                    fetchData_d = word_d;
                    state_d     = WRITE;
                end
            end
            WRITE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clkIn or negedge rstIn) begin
        if (!rstIn) begin
            state_q     <= IDLE;
            lineAddr_q  <= '0;
            issueCnt_q  <= 2'd0;
            rcvCnt_q    <= 2'd0;
            capPend_q   <= 1'b0;
            drop_q      <= 1'b0;
            word_q      <= 32'd0;
            fetchRdy_q  <= 1'b0;
            fetchData_q <= 32'd0;
        end else if (rdyIn) begin
            state_q     <= state_d;
            lineAddr_q  <= lineAddr_d;
            issueCnt_q  <= issueCnt_d;
            rcvCnt_q    <= rcvCnt_d;
            capPend_q   <= capPend_d;
            drop_q      <= drop_d;
            word_q      <= word_d;
            fetchRdy_q  <= fetchRdy_d;
            fetchData_q <= fetchData_d;
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] hitCnt_q, missCnt_q;

    always_ff @(posedge clkIn or negedge rstIn) begin
        if (!rstIn) begin
            hitCnt_q  <= '0;
            missCnt_q <= '0;
        end else if (rdyIn && accept) begin
            if (cacheHit) hitCnt_q <= hitCnt_q + 1'b1;
            else          missCnt_q <= missCnt_q + 1'b1;
        end
    end

    assign hitCnt  = hitCnt_q;
    assign missCnt = missCnt_q;
`endif

    // a flush in the delivery cycle suppresses the pulse
    assign fetchRdy    = fetchRdy_q && !fetchFlush;
    assign fetchData   = fetchData_q;
    assign fetchBusy   = (state_q != IDLE);
    assign cacheAddr   = (state_q == IDLE) ? fetchAddr : {lineAddr_q, 2'b00};
    assign cacheWrEn   = (state_q == WRITE);
    assign cacheWrData = word_q;
    assign memReq      = (state_q == REFILL);
    assign memAddr     = {lineAddr_q, issueCnt_q};

endmodule

// File: tb/tb_icache_fetch_ctrl.sv
// Self-checking bench for icache_fetch_ctrl: directed scenarios plus random
// hit/miss transactions against a transaction-level reference model.
module tb_icache_fetch_ctrl;

    logic        clkIn = 1'b0;
    logic        rstIn, rdyIn, fetchReq, fetchFlush, cacheHit, memGnt;
    logic [31:0] fetchAddr, cacheAddr, memAddr;
    logic [31:0] cacheData, fetchData, cacheWrData;
    logic [7:0]  memData;
    logic        fetchBusy, fetchRdy, cacheWrEn, memReq;
`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] hitCnt, missCnt;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int mHits = 0;
    int mMiss = 0;

    icache_fetch_ctrl dut (
        .clkIn(clkIn), .rstIn(rstIn), .rdyIn(rdyIn),
        .fetchReq(fetchReq), .fetchAddr(fetchAddr), .fetchFlush(fetchFlush),
        .fetchBusy(fetchBusy), .fetchRdy(fetchRdy), .fetchData(fetchData),
        .cacheAddr(cacheAddr), .cacheHit(cacheHit), .cacheData(cacheData),
        .cacheWrEn(cacheWrEn), .cacheWrData(cacheWrData),
        .memReq(memReq), .memAddr(memAddr), .memGnt(memGnt), .memData(memData)
`ifdef ICACHE_PERF_CNT_EN
        , .hitCnt(hitCnt), .missCnt(missCnt)
`endif
    );

    always #5 clkIn = ~clkIn;
    always @(posedge clkIn) cyc++;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clkIn);
        @(negedge clkIn);
    endtask

    task automatic idle_in();
        fetchReq   = 1'b0;
        fetchFlush = 1'b0;
        memGnt     = 1'b0;
        cacheHit   = 1'b0;
        rdyIn      = 1'b1;
    endtask

    // hit: data due one cycle later unless flushed in either cycle
    task automatic do_hit(input logic [31:0] a, input logic [31:0] d,
                          input bit fl0, input bit fl1);
        fetchReq = 1'b1; fetchAddr = a; cacheHit = 1'b1;
        cacheData = d; fetchFlush = fl0; memGnt = 1'b0;
        #1;
        chk("hit_caddr", cacheAddr, a);
        chk("hit_busy0", fetchBusy, 0);
        step();
        if (!fl0) mHits++;
        fetchReq = 1'b0; cacheHit = 1'b0;
        cacheData = $urandom; fetchFlush = fl1;
        #1;
        chk("hit_rdy", fetchRdy, !(fl0 || fl1));
        if (!(fl0 || fl1)) chk("hit_data", fetchData, d);
        chk("hit_memreq", memReq, 0);
        chk("hit_busy1", fetchBusy, 0);
        fetchFlush = 1'b0;
        step();
    endtask

    // miss: model counts grants; WRITE is two cycles after the 4th grant
    task automatic do_miss(input logic [31:0] a, input logic [31:0] word,
                           input int mode, input int flushAt,
                           input int stallAt, output int tw, output int twAbs);
        int grants, tDone, prevIdx, c0;
        bit prevValid, flushed;
        logic [1:0] g2;
        logic [31:0] line;
        line = {a[31:2], 2'b00};
        tw = -1; twAbs = -1;
        grants = 0; tDone = -1; prevIdx = 0;
        prevValid = 0; flushed = 0;
        fetchReq = 1'b1; fetchAddr = a; cacheHit = 1'b0;
        fetchFlush = 1'b0; memGnt = 1'b0; memData = 8'($urandom);
        #1;
        c0 = cyc;
        chk("miss_caddr0", cacheAddr, a);
        chk("miss_busy0", fetchBusy, 0);
        step();
        mMiss++;
        for (int t = 1; t <= 200; t++) begin
            fetchReq  = 1'($urandom_range(0, 1));
            fetchAddr = $urandom;
            cacheHit  = 1'($urandom_range(0, 1));
            memData   = prevValid ? word[8*prevIdx +: 8] : 8'($urandom);
            if (mode == 0)      memGnt = 1'b1;
            else if (mode == 1) memGnt = (t % 2 == 0);
            else                memGnt = (t > 40) ? 1'b1 : 1'($urandom_range(0, 1));
            fetchFlush = (t == flushAt);
            if (fetchFlush) flushed = 1;
            g2 = grants[1:0];
            if (t == stallAt) begin
                rdyIn = 1'b0;
                repeat (5) begin
                    #1;
                    chk("stall_busy", fetchBusy, 1);
                    chk("stall_req", memReq, grants < 4);
                    chk("stall_wr", cacheWrEn, 0);
                    if (grants < 4) chk("stall_maddr", memAddr, {a[31:2], g2});
                    step();
                end
                rdyIn = 1'b1;
            end
            #1;
            if (tDone >= 0 && t == tDone + 2) begin
                chk("wr_en", cacheWrEn, 1);
                chk("wr_data", cacheWrData, word);
                chk("wr_caddr", cacheAddr, line);
                chk("wr_rdy", fetchRdy, !flushed);
                if (!flushed) chk("wr_fdata", fetchData, word);
                chk("wr_memreq", memReq, 0);
                tw = t;
                twAbs = cyc - c0;
                step();
                break;
            end
            chk("rf_busy", fetchBusy, 1);
            chk("rf_wren", cacheWrEn, 0);
            chk("rf_rdy", fetchRdy, 0);
            chk("rf_memreq", memReq, grants < 4);
            chk("rf_caddr", cacheAddr, line);
            if (grants < 4) chk("rf_maddr", memAddr, {a[31:2], g2});
            prevValid = memGnt && (grants < 4);
            prevIdx = grants;
            if (prevValid) grants++;
            if (grants == 4 && tDone < 0) tDone = t;
            step();
        end
        if (tw < 0) chk("miss_timeout", 1, 0);
        idle_in();
        #1;
        chk("post_busy", fetchBusy, 0);
        chk("post_wren", cacheWrEn, 0);
        chk("post_rdy", fetchRdy, 0);
    endtask

    initial begin
        int tw, tabs;
        logic [31:0] a, w;
        rstIn = 1'b0;
        idle_in();
        fetchAddr = 32'h0; cacheData = 32'h0; memData = 8'h0;
        #1;
        chk("rst_rdy", fetchRdy, 0);
        chk("rst_busy", fetchBusy, 0);
        chk("rst_wren", cacheWrEn, 0);
        chk("rst_memreq", memReq, 0);
        chk("rst_fdata", fetchData, 0);
        chk("rst_wdata", cacheWrData, 0);
        chk("rst_maddr", memAddr, 0);
        step();
        step();
        rstIn = 1'b1;
        step();

        do_miss(32'h1000, 32'h00A00013, 0, -1, -1, tw, tabs);
        chk("cold_lat", tw, 6);
        do_hit(32'h1000, 32'h00A00013, 0, 0);
        do_miss(32'h1000, 32'h8badf00d, 1, -1, -1, tw, tabs);
        chk("alt_lat", tw, 10);
        do_miss(32'h2004, 32'h12345678, 0, 3, -1, tw, tabs);
        chk("flush_lat", tw, 6);
        do_miss(32'h3008, 32'hcafe0001, 0, -1, 2, tw, tabs);
        chk("stall_lat", tw, 6);
        chk("stall_abs", tabs, 11);
        do_miss(32'h400c, 32'h0f0e0d0c, 0, 6, -1, tw, tabs);
        do_hit(32'h5000, 32'h11112222, 1, 0);
        do_hit(32'h5004, 32'h33334444, 0, 1);
        do_hit(32'h5008, 32'h55556666, 0, 0);

        for (int i = 0; i < 30; i++) begin
            a = $urandom;
            w = $urandom;
            if ($urandom_range(0, 2) == 0)
                do_hit(a, w, $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0);
            else
                do_miss(a, w, 2,
                        ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 12)) : -1,
                        ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : -1,
                        tw, tabs);
        end
`ifdef ICACHE_PERF_CNT_EN
        chk("hitCnt", hitCnt, mHits);
        chk("missCnt", missCnt, mMiss);
`endif

        fetchReq = 1'b1; fetchAddr = 32'h2000; cacheHit = 1'b0;
        step();
        fetchReq = 1'b0; memGnt = 1'b1; memData = 8'h5a;
        step();
        step();
        #1;
        rstIn = 1'b0;
        #1;
        mHits = 0; mMiss = 0;
        chk("arst_busy", fetchBusy, 0);
        chk("arst_rdy", fetchRdy, 0);
        chk("arst_wren", cacheWrEn, 0);
        chk("arst_memreq", memReq, 0);
        chk("arst_maddr", memAddr, 0);
        chk("arst_fdata", fetchData, 0);
        chk("arst_wdata", cacheWrData, 0);
`ifdef ICACHE_PERF_CNT_EN
        chk("arst_miss", missCnt, mMiss);
        chk("arst_hit", hitCnt, mHits);
`endif
        step();
        rstIn = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("arst_nowr", cacheWrEn, 0);
            chk("arst_nordy", fetchRdy, 0);
            chk("arst_idle", fetchBusy, 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
